uart_byte_fifo: RTL and testbench

Synchronous single-clock byte FIFO that buffers UART data on either side of `uart_control`. On the receive side it is written by the RX done strobe and popped by the software read pulse. On the transmit side it is filled by the register interface and popped by the TX read pulse. It exports the 11-bit status word that `uart_control` decodes: full flag, empty flag and byte count.

---
 rtl/uart_byte_fifo.sv | 122 ++++++++++++
 tb/tb_uart_byte_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// uart_byte_fifo : single-clock byte FIFO with registered count/flags and
//                  sticky overflow/underflow, buffering UART RX/TX data.
// Revision       : 1.0
// ============================================================================
module uart_byte_fifo #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                clr,
   input  logic                wr_en,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                rd_en,
   output logic [DATA_W-1:0]   rd_data,
   output logic [ADDR_W+2:0]   status,
   output logic                overflow,
   output logic                underflow
);

   localparam int          DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              push_ok;
   logic              pop_ok;

   // Accept decisions use the registered flags; a full FIFO still takes a
   // push when a pop frees the slot on the same edge.
   always_comb begin
      push_ok     = 1'b0;
      pop_ok      = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      rd_data_d   = rd_data_q;

      if (clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         push_ok = wr_en & (~full_q | rd_en);
         pop_ok  = rd_en & ~empty_q;

         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
            rd_data_d = mem_q[rd_ptr_q];
         end

         if (push_ok && !pop_ok) begin
            count_d = count_q + (ADDR_W + 1)'(1);
         end else if (pop_ok && !push_ok) begin
            count_d = count_q - (ADDR_W + 1)'(1);
         end

         if (wr_en && !push_ok) begin
            overflow_d = 1'b1;
         end
         if (rd_en && !pop_ok) begin
            underflow_d = 1'b1;
         end
      end

      full_d  = (count_d == CNT_FULL);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge Clk) begin
      if (!Rst && push_ok) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data   = rd_data_q;
   assign status    = {count_q, empty_q, full_q};
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_byte_fifo : directed stimulus with a queue-based reference model.
// Revision          : 1.0
// ============================================================================
module tb_uart_byte_fifo;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        clr = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_data = '0;
   logic        rd_en = 1'b0;
   logic [7:0]  rd_data;
   logic [10:0] status;
   logic        overflow;
   logic        underflow;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // reference model state
   byte unsigned q[$];
   logic [7:0]   m_rd  = '0;
   logic         m_ovf = 1'b0;
   logic         m_udf = 1'b0;

   uart_byte_fifo #(.DATA_W(8), .ADDR_W(8)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .clr       (clr),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .status    (status),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      bit full, empty, push, pop;
      if (Rst) begin
         q.delete();
         m_rd  = '0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
         chk_en = 1'b1;
      end else if (clr) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         full  = (q.size() == 256);
         empty = (q.size() == 0);
         pop   = rd_en && !empty;
         push  = wr_en && (!full || rd_en);
         if (pop) m_rd = q.pop_front();
         if (push) q.push_back(wr_data);
         if (wr_en && !push) m_ovf = 1'b1;
         if (rd_en && !pop) m_udf = 1'b1;
      end
   end

   function automatic logic [10:0] model_status();
      logic [8:0] c;
      c = 9'(q.size());
      return {c, (q.size() == 0), (q.size() == 256)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (chk_en) begin
         chk("model_status",    32'(status),    32'(model_status()));
         chk("model_rd_data",   32'(rd_data),   32'(m_rd));
         chk("model_overflow",  32'(overflow),  32'(m_ovf));
         chk("model_underflow", 32'(underflow), 32'(m_udf));
      end
   end

   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      clr     = c;
      @(posedge Clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      clr   = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("reset_status", 32'(status), 32'h002);
      chk("reset_rd_data", 32'(rd_data), 32'h00);
      chk("reset_flags", 32'({overflow, underflow}), 32'h0);

      // basic ordering and count
      step(1'b1, 8'h11, 1'b0, 1'b0); chk("count1", 32'(status[10:2]), 1);
      step(1'b1, 8'h22, 1'b0, 1'b0); chk("count2", 32'(status[10:2]), 2);
      step(1'b1, 8'h33, 1'b0, 1'b0); chk("count3", 32'(status[10:2]), 3);
      step(1'b0, 8'h00, 1'b1, 1'b0); chk("pop_11", 32'(rd_data), 32'h11);
      chk("count_after_pop1", 32'(status[10:2]), 2);
      step(1'b0, 8'h00, 1'b1, 1'b0); chk("pop_22", 32'(rd_data), 32'h22);
      step(1'b0, 8'h00, 1'b1, 1'b0); chk("pop_33", 32'(rd_data), 32'h33);
      chk("empty_after_drain", 32'(status), 32'h002);

      // fill to full
      for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("full_status", 32'(status), 32'h401);
      // simultaneous push/pop while full
      step(1'b1, 8'h5A, 1'b1, 1'b0);
      chk("full_rw_rd_data", 32'(rd_data), 32'h00);
      chk("full_rw_status", 32'(status), 32'h401);
      chk("full_rw_no_ovf", 32'(overflow), 32'h0);
      // dropped push
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("overflow_set", 32'(overflow), 32'h1);
      chk("overflow_count", 32'(status), 32'h401);
      // drain: 0x01..0xFF then the wrapped 0x5A
      step(1'b0, 8'h00, 1'b1, 1'b0); chk("drain_first", 32'(rd_data), 32'h01);
      for (int i = 1; i < 255; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_ff", 32'(rd_data), 32'hFF);
      step(1'b0, 8'h00, 1'b1, 1'b0); chk("drain_wrap_5a", 32'(rd_data), 32'h5A);
      chk("drained_status", 32'(status), 32'h002);

      // flush, then simultaneous push/pop on empty
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_flags", 32'({overflow, underflow}), 32'h0);
      step(1'b1, 8'h77, 1'b1, 1'b0);
      chk("empty_rw_udf", 32'(underflow), 32'h1);
      chk("empty_rw_rd_data", 32'(rd_data), 32'h5A);
      chk("empty_rw_count", 32'(status), 32'h004);
      step(1'b0, 8'h00, 1'b1, 1'b0); chk("pop_77", 32'(rd_data), 32'h77);

      // clr with concurrent push
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0); chk("pop_80", 32'(rd_data), 32'h80);
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      chk("clr_status", 32'(status), 32'h002);
      chk("clr_keeps_rd", 32'(rd_data), 32'h80);
      chk("clr_clears_flags", 32'({overflow, underflow}), 32'h0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("udf_after_clr", 32'(underflow), 32'h1);

      // reset mid-stream
      step(1'b1, 8'h01, 1'b0, 1'b0);
      step(1'b1, 8'h02, 1'b1, 1'b0);
      Rst = 1'b1;
      step(1'b1, 8'h03, 1'b0, 1'b0);
      Rst = 1'b0;
      chk("midrst_status", 32'(status), 32'h002);
      chk("midrst_rd_data", 32'(rd_data), 32'h00);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
